mtimer: RTL and testbench

MTIMER -- requirements
Module: mtimer

---
 rtl/mtimer.sv | 154 +++++++++++++++
 tb/tb_mtimer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtimer.sv
// mtimer: 64-bit memory-mapped machine timer with compare interrupt.
//
// Register window (64 bytes at BASE_ADDR, word accesses only):
//   0x00 MTIME_LO     0x04 MTIME_HI (reads hi_shadow)
//   0x08 MTIMECMP_LO  0x0C MTIMECMP_HI
//   0x10 CTRL         bit0 CNT_EN, bit1 IRQ_EN
//   0x14 PRESCALE     present only with MTIMER_PRESCALE_EN defined
//
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   rd_en, wr_en    bus read / write strobes
//   addr            byte address
//   wdata           write data
//   rdata           combinational read data (0 when not selected)
//   timer_interrupt registered level interrupt
//
// Build option: define MTIMER_PRESCALE_EN to add the tick prescaler.
module mtimer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_F000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        timer_interrupt
);

    localparam logic [3:0] OFF_MTIME_LO    = 4'd0;
    localparam logic [3:0] OFF_MTIME_HI    = 4'd1;
    localparam logic [3:0] OFF_MTIMECMP_LO = 4'd2;
    localparam logic [3:0] OFF_MTIMECMP_HI = 4'd3;
    localparam logic [3:0] OFF_CTRL        = 4'd4;
    localparam logic [3:0] OFF_PRESCALE    = 4'd5;

    logic        sel;
    logic        wr;
    logic        rd;
    logic [3:0]  idx;
    logic        tick;
    logic [31:0] prescale_rd;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] hi_shadow_q, hi_shadow_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        irq_q, irq_d;

    assign sel = (addr[31:6] == BASE_ADDR[31:6]) && (addr[1:0] == 2'b00);
    assign wr  = wr_en && sel;
    assign rd  = rd_en && sel;
    assign idx = addr[5:2];

`ifdef MTIMER_PRESCALE_EN
    logic [31:0] prescale_q, prescale_d;
    logic [31:0] presc_cnt_q, presc_cnt_d;

    // Counter advances only on CNT_EN cycles; a tick fires on the cycle it matches PRESCALE.
    always_comb begin
        prescale_d  = prescale_q;
        presc_cnt_d = presc_cnt_q;
        tick        = 1'b0;
        if (ctrl_q[0]) begin
            if (presc_cnt_q == prescale_q) begin
                tick        = 1'b1;
                presc_cnt_d = 32'd0;
            end else begin
                presc_cnt_d = presc_cnt_q + 32'd1;
            end
        end
        if (wr && (idx == OFF_PRESCALE)) begin
            prescale_d  = wdata;
            presc_cnt_d = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_q  <= 32'd0;
            presc_cnt_q <= 32'd0;
        end else begin
            prescale_q  <= prescale_d;
            presc_cnt_q <= presc_cnt_d;
        end
    end

    assign prescale_rd = prescale_q;
`else
    assign tick        = ctrl_q[0];
    assign prescale_rd = 32'd0;
`endif

    always_comb begin
        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        hi_shadow_d = hi_shadow_q;
        ctrl_d      = ctrl_q;

        // A write to either mtime half wins over the tick for the whole counter.
        if (wr && (idx == OFF_MTIME_LO)) begin
            mtime_d[31:0] = wdata;
        end else if (wr && (idx == OFF_MTIME_HI)) begin
            mtime_d[63:32] = wdata;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        if (wr && (idx == OFF_MTIMECMP_LO)) mtimecmp_d[31:0]  = wdata;
        if (wr && (idx == OFF_MTIMECMP_HI)) mtimecmp_d[63:32] = wdata;
        if (wr && (idx == OFF_CTRL))        ctrl_d            = wdata[1:0];

        // Snapshot the upper half so a following HI read matches the LO just returned.
        if (rd && (idx == OFF_MTIME_LO)) hi_shadow_d = mtime_q[63:32];

        irq_d = ctrl_q[1] && (mtime_q >= mtimecmp_q);
    end

    always_comb begin
        rdata = 32'd0;
        if (rd) begin
            case (idx)
                OFF_MTIME_LO:    rdata = mtime_q[31:0];
                OFF_MTIME_HI:    rdata = hi_shadow_q;
                OFF_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
                OFF_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
                OFF_CTRL:        rdata = {30'd0, ctrl_q};
                OFF_PRESCALE:    rdata = prescale_rd;
                default:         rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            hi_shadow_q <= 32'd0;
            ctrl_q      <= 2'd0;
            irq_q       <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            hi_shadow_q <= hi_shadow_d;
            ctrl_q      <= ctrl_d;
            irq_q       <= irq_d;
        end
    end

    assign timer_interrupt = irq_q;

endmodule

// File: tb/tb_mtimer.sv
module tb_mtimer;

    localparam logic [31:0] BASE   = 32'h0000_F000;
    localparam logic [31:0] A_LO   = BASE + 32'h00;
    localparam logic [31:0] A_HI   = BASE + 32'h04;
    localparam logic [31:0] A_CLO  = BASE + 32'h08;
    localparam logic [31:0] A_CHI  = BASE + 32'h0C;
    localparam logic [31:0] A_CTRL = BASE + 32'h10;
    localparam logic [31:0] A_PRE  = BASE + 32'h14;
    localparam logic [31:0] A_OUT  = 32'h0000_E000;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        timer_interrupt;

    logic [31:0] exp_q[$];
    int checks;
    int errors;

    mtimer #(.BASE_ADDR(BASE)) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_en           (rd_en),
        .wr_en           (wr_en),
        .addr            (addr),
        .wdata           (wdata),
        .rdata           (rdata),
        .timer_interrupt (timer_interrupt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // All bus tasks start at a falling edge and return at the next falling edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        rd_en = 1'b1;
        addr  = a;
        #1 d = rdata;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic bus_rw(input logic [31:0] a, input logic [31:0] wd, output logic [31:0] d);
        rd_en = 1'b1;
        wr_en = 1'b1;
        addr  = a;
        wdata = wd;
        #1 d = rdata;
        @(negedge clk);
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] a_tab[7];
        logic [31:0] e_tab[7];
        logic [31:0] got;
        logic [31:0] e;
        a_tab = '{A_HI, A_LO, A_CLO, A_CHI, A_CTRL, A_PRE, A_OUT};
        e_tab = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
        exp_q.push_back(32'd0);
        got = {31'd0, timer_interrupt};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset_irq got %h exp %h", got, e);
        end
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(e_tab[i]);
            bus_read(a_tab[i], got);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_reg addr %h got %h exp %h", a_tab[i], got, e);
            end
        end
    endtask

    task automatic test_irq_compare();
        logic [31:0] got;
        logic [31:0] e;
        bus_write(A_CHI, 32'd0);
        bus_write(A_CLO, 32'd10);
        bus_write(A_CTRL, 32'd3);
        // mtime reaches 10 at the 10th edge after CTRL; irq follows one edge later.
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            exp_q.push_back((i >= 11) ? 32'd1 : 32'd0);
            got = {31'd0, timer_interrupt};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL irq_compare cycle %0d got %h exp %h", i, got, e);
            end
        end
        exp_q.push_back(32'd14);
        bus_read(A_LO, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL irq_compare_mtime got %h exp %h", got, e);
        end
        bus_write(A_CTRL, 32'd0);
    endtask

    task automatic test_carry();
        logic [31:0] got;
        logic [31:0] e;
        bus_write(A_LO, 32'hFFFF_FFFE);
        bus_write(A_HI, 32'd0);
        bus_write(A_CTRL, 32'd1);
        @(negedge clk);
        bus_write(A_CTRL, 32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        bus_read(A_LO, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL carry_lo got %h exp %h", got, e);
        end
        bus_read(A_HI, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL carry_hi got %h exp %h", got, e);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] got;
        logic [31:0] e;
        bus_write(A_CLO, 32'hFFFF_FFFF);
        bus_write(A_CHI, 32'hFFFF_FFFF);
        bus_write(A_LO, 32'hFFFF_FFFF);
        bus_write(A_HI, 32'hFFFF_FFFF);
        bus_write(A_CTRL, 32'd2);
        @(negedge clk);
        exp_q.push_back(32'd1);
        got = {31'd0, timer_interrupt};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL wrap_irq_before got %h exp %h", got, e);
        end
        bus_write(A_CTRL, 32'd3);
        bus_write(A_CTRL, 32'd2);
        // Exactly one tick has happened: mtime wrapped, irq not yet affected.
        exp_q.push_back(32'd1);
        got = {31'd0, timer_interrupt};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL wrap_irq_at_wrap got %h exp %h", got, e);
        end
        @(negedge clk);
        exp_q.push_back(32'd0);
        got = {31'd0, timer_interrupt};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL wrap_irq_after got %h exp %h", got, e);
        end
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        bus_read(A_LO, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL wrap_lo got %h exp %h", got, e);
        end
        bus_read(A_HI, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL wrap_hi got %h exp %h", got, e);
        end
        bus_write(A_CTRL, 32'd0);
    endtask

    task automatic test_cmp_clear();
        logic [31:0] got;
        logic [31:0] e;
        logic [31:0] e_tab[4];
        e_tab = '{32'd1, 32'd1, 32'd1, 32'd0};
        bus_write(A_LO, 32'd200);
        bus_write(A_HI, 32'd5);
        bus_write(A_CLO, 32'd0);
        bus_write(A_CHI, 32'd0);
        bus_write(A_CTRL, 32'd2);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) @(negedge clk);
            if (i == 1) bus_write(A_CLO, 32'd300);
            if (i == 2) bus_write(A_CHI, 32'd6);
            if (i == 3) @(negedge clk);
            exp_q.push_back(e_tab[i]);
            got = {31'd0, timer_interrupt};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL cmp_clear step %0d got %h exp %h", i, got, e);
            end
        end
        bus_write(A_CTRL, 32'd0);
    endtask

    task automatic test_rw_same();
        logic [31:0] got;
        logic [31:0] e;
        exp_q.push_back(32'd300);
        bus_rw(A_CLO, 32'h0000_1234, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL rw_same_old got %h exp %h", got, e);
        end
        bus_write(BASE + 32'h09, 32'hDEAD_BEEF);
        bus_write(A_OUT + 32'h08, 32'hCAFE_F00D);
        bus_write(A_CTRL, 32'hFFFF_FFF2);
        exp_q.push_back(32'h0000_1234);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        bus_read(A_CLO, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL rw_same_new got %h exp %h", got, e);
        end
        bus_read(A_CTRL, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL ctrl_mask got %h exp %h", got, e);
        end
        bus_read(BASE + 32'h18, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL unused_offset got %h exp %h", got, e);
        end
        bus_read(A_OUT, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL out_of_window got %h exp %h", got, e);
        end
        bus_write(A_CTRL, 32'd0);
    endtask

    task automatic test_prescale();
        logic [31:0] got;
        logic [31:0] e;
        bus_write(A_LO, 32'd0);
        bus_write(A_HI, 32'd0);
        bus_write(A_PRE, 32'd3);
        bus_write(A_CTRL, 32'd1);
        repeat (11) @(negedge clk);
        bus_write(A_CTRL, 32'd0);
`ifdef MTIMER_PRESCALE_EN
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd3);
`else
        exp_q.push_back(32'd12);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
`endif
        bus_read(A_LO, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL prescale_mtime got %h exp %h", got, e);
        end
        bus_read(A_HI, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL prescale_hi got %h exp %h", got, e);
        end
        bus_read(A_PRE, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL prescale_reg got %h exp %h", got, e);
        end
    endtask

    task automatic test_reset_priority();
        logic [31:0] got;
        logic [31:0] e;
        bus_write(A_PRE, 32'd0);
        bus_write(A_HI, 32'd7);
        bus_write(A_LO, 32'd0);
        bus_write(A_CLO, 32'd0);
        bus_write(A_CHI, 32'd0);
        bus_write(A_CTRL, 32'd3);
        @(negedge clk);
        exp_q.push_back(32'd1);
        got = {31'd0, timer_interrupt};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL rstprio_irq_before got %h exp %h", got, e);
        end
        bus_read(A_LO, got);
        // Reset together with a competing write while counting with irq high.
        rst   = 1'b1;
        wr_en = 1'b1;
        addr  = A_LO;
        wdata = 32'h0000_0055;
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 1'b0;
        test_reset();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        rd_en  = 1'b0;
        wr_en  = 1'b0;
        addr   = 32'd0;
        wdata  = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_irq_compare();
        test_carry();
        test_wrap();
        test_cmp_clear();
        test_rw_same();
        test_prescale();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
